// File: rtl/axis_pkt_buf_mem.sv
// Beat storage for axis_pkt_buf: DEPTH words of {TLAST, TDATA}.
// It has one synchronous write port, an asynchronous read port, and no reset.
module axis_pkt_buf_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH:0]   i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH:0]   o_rd_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The head word must be visible in the same cycle rd_ptr moves, so the read is not registered.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_pkt_buf.sv
// Store-and-forward AXI-Stream packet buffer: a packet is offered downstream only after
// its TLAST beat is stored; packets larger than the whole buffer are dropped whole.
module axis_pkt_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] src_TDATA,
    input  logic                  src_TVALID,
    output logic                  src_TREADY,
    input  logic                  src_TLAST,
    output logic [DATA_WIDTH-1:0] res_TDATA,
    output logic                  res_TVALID,
    input  logic                  res_TREADY,
    output logic                  res_TLAST,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic [7:0]            drop_count
);
    localparam int               PTR_W     = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH     = PTR_W'(2 ** ADDR_WIDTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic             ST_ACCEPT = 1'b0;
    localparam logic             ST_DROP   = 1'b1;

    typedef enum logic {
        ACCEPT = ST_ACCEPT,
        DROP   = ST_DROP
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_commit_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [ADDR_WIDTH:0]  r_pkt_count;
    logic [7:0]           r_drop_count;

    logic [PTR_W-1:0]     w_used;
    logic                 w_full;
    logic                 w_avail;
    logic                 w_src_ready;
    logic                 w_src_hs;
    logic                 w_wr_en;
    logic                 w_commit;
    logic                 w_drop_start;
    logic                 w_drop_end;
    logic                 w_rd_fire;
    logic [DATA_WIDTH:0]  w_rd_word;

    assign w_used  = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_used == DEPTH);
    assign w_avail = (r_rd_ptr != r_commit_ptr);

    // Ready depends on registered state only, never on res_TREADY.
    assign w_src_ready = (r_state == DROP) | ~w_full;
    assign src_TREADY  = w_src_ready & ~rst;
    assign res_TVALID  = w_avail & ~rst;

    assign w_src_hs     = src_TVALID & src_TREADY;
    assign w_wr_en      = w_src_hs & (r_state == ACCEPT);
    assign w_commit     = w_wr_en & src_TLAST;
    // Full with nothing committed means the packet in flight can never fit.
    assign w_drop_start = (r_state == ACCEPT) & w_full & (r_commit_ptr == r_rd_ptr);
    assign w_drop_end   = w_src_hs & (r_state == DROP) & src_TLAST;
    assign w_rd_fire    = res_TVALID & res_TREADY;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCEPT: if (w_drop_start) w_state_next = DROP;
            DROP:   if (w_drop_end)   w_state_next = ACCEPT;
            default: w_state_next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCEPT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
        end else begin
            if (w_drop_start) begin
                r_wr_ptr <= r_commit_ptr;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_commit) begin
                r_commit_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            case ({w_commit, w_rd_fire & w_rd_word[DATA_WIDTH]})
                2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
                2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
                default: r_pkt_count <= r_pkt_count;
            endcase
            if (w_drop_end) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    axis_pkt_buf_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data ({src_TLAST, src_TDATA}),
        .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (w_rd_word)
    );

    assign res_TDATA  = w_rd_word[DATA_WIDTH-1:0];
    assign res_TLAST  = w_rd_word[DATA_WIDTH];
    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_axis_pkt_buf.sv
// Bench for axis_pkt_buf: directed scenarios plus a random soak, scored against a
// packet-level model (committed-beat queue, drop rule by packet length).
module tb_axis_pkt_buf;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] src_TDATA = '0;
    logic          src_TVALID = 1'b0;
    logic          src_TREADY;
    logic          src_TLAST = 1'b0;
    logic [DW-1:0] res_TDATA;
    logic          res_TVALID;
    logic          res_TREADY = 1'b0;
    logic          res_TLAST;
    logic [AW:0]   pkt_count;
    logic [7:0]    drop_count;

    always #5 clk = ~clk;

    axis_pkt_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_TDATA  (src_TDATA),
        .src_TVALID (src_TVALID),
        .src_TREADY (src_TREADY),
        .src_TLAST  (src_TLAST),
        .res_TDATA  (res_TDATA),
        .res_TVALID (res_TVALID),
        .res_TREADY (res_TREADY),
        .res_TLAST  (res_TLAST),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: beats of committed packets awaiting output, and the packet being received.
    logic [DW:0] exp_q[$];
    logic [DW:0] cur_q[$];
    int com_pkts = 0, rd_pkts = 0, drops_m = 0;
    int out_beats = 0, out_lasts = 0, rv_cycles = 0, out_pkt_len = 0;

    logic          s_srdy, s_rv, s_rl, last_in_hs, last_out_hs;
    logic [DW-1:0] s_rd;
    logic [AW:0]   s_pc;
    logic          prev_rv = 1'b0, prev_hs = 1'b0;
    logic [DW:0]   prev_word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample, score, advance past the next rising edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic rr);
        logic [DW:0] w;
        src_TVALID = v;
        src_TDATA  = d;
        src_TLAST  = l;
        res_TREADY = rr;
        #1;
        s_srdy = src_TREADY;
        s_rv   = res_TVALID;
        s_rd   = res_TDATA;
        s_rl   = res_TLAST;
        s_pc   = pkt_count;
        check("valid_vs_committed", 32'(s_rv), 32'(exp_q.size() != 0));
        check("pkt_count", 32'(s_pc), 32'(com_pkts - rd_pkts));
        check("drop_count", 32'(drop_count), 32'(drops_m % 256));
        if (prev_rv && !prev_hs) begin
            check("hold_valid", 32'(s_rv), 32'(1));
            check("hold_data", 32'({s_rl, s_rd}), 32'(prev_word));
        end
        last_out_hs = s_rv & rr;
        last_in_hs  = v & s_srdy;
        if (s_rv) rv_cycles++;
        if (last_out_hs && exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("res_TDATA", 32'(s_rd), 32'(w[DW-1:0]));
            check("res_TLAST", 32'(s_rl), 32'(w[DW]));
            out_beats++;
            out_pkt_len++;
            if (w[DW]) begin
                rd_pkts++;
                out_lasts++;
                $display("[%0t] out packet %0d: %0d beats, last data 0x%02h", $time, rd_pkts, out_pkt_len, w[DW-1:0]);
                out_pkt_len = 0;
            end
        end
        if (last_in_hs) begin
            cur_q.push_back({l, d});
            if (l) begin
                if (cur_q.size() <= DEPTH) begin
                    foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                    com_pkts++;
                end else begin
                    drops_m++;
                    $display("[%0t] in packet of %0d beats dropped", $time, cur_q.size());
                end
                cur_q.delete();
            end
        end
        prev_rv   = s_rv;
        prev_hs   = last_out_hs;
        prev_word = {s_rl, s_rd};
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends beats first..first+cnt-1 of a len-beat packet (data = base+index), bounded by budget cycles.
    task automatic send(input logic [DW-1:0] base, input int first, input int cnt, input int len,
                        input logic rr, input int budget, output int sent);
        int cyc;
        int idx;
        sent = 0;
        cyc  = 0;
        while (sent < cnt && cyc < budget) begin
            idx = first + sent;
            step(1'b1, base + DW'(idx), idx == len - 1, rr);
            if (last_in_hs) sent++;
            cyc++;
        end
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rr);
    endtask

    initial begin
        int sent, t0, t1, p, b, len, cyc, sent_beats;
        logic vv, rr;
        logic [DW-1:0] dd;

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_res_TVALID", 32'(res_TVALID), 32'(0));
        check("reset_src_TREADY", 32'(src_TREADY), 32'(0));
        check("reset_pkt_count", 32'(pkt_count), 32'(0));
        check("reset_drop_count", 32'(drop_count), 32'(0));
        rst = 1'b0;

        // 1. Single 4-beat packet, output only after TLAST is stored
        for (int i = 0; i < 4; i++) begin
            step(1'b1, DW'(8'h10 + i), i == 3, 1'b1);
            check("t1_src_ready", 32'(s_srdy), 32'(1));
            check("t1_valid_low", 32'(s_rv), 32'(0));
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            check("t1_valid", 32'(s_rv), 32'(1));
            check("t1_data", 32'(s_rd), 32'(8'h10 + i));
            check("t1_last", 32'(s_rl), 32'(i == 3));
            check("t1_pkt_count_1", 32'(s_pc), 32'(1));
        end
        step(1'b0, '0, 1'b0, 1'b1);
        check("t1_pkt_count_0", 32'(s_pc), 32'(0));
        check("t1_valid_end", 32'(s_rv), 32'(0));

        // 2. Backpressure: three 5-beat packets, 4th packet stalls after 1 beat
        t0 = out_beats;
        for (int k = 0; k < 3; k++) begin
            send(DW'(8'h20 + 8 * k), 0, 5, 5, 1'b0, 5, sent);
            check("t2_pkt_sent", 32'(sent), 32'(5));
        end
        send(8'h40, 0, 5, 5, 1'b0, 6, sent);
        check("t2_4th_accepted", 32'(sent), 32'(1));
        check("t2_src_ready_low", 32'(s_srdy), 32'(0));
        check("t2_pkt_count", 32'(s_pc), 32'(3));
        check("t2_drop_count", 32'(drop_count), 32'(0));
        send(8'h40, 1, 4, 5, 1'b1, 40, sent);
        check("t2_4th_rest", 32'(sent), 32'(4));
        idle(30, 1'b1);
        check("t2_delivered", 32'(out_beats - t0), 32'(20));

        // 3. Oversize 20-beat packet into an empty buffer
        t0 = out_beats;
        t1 = rv_cycles;
        send(8'h50, 0, 16, 20, 1'b1, 16, sent);
        check("t3_stored", 32'(sent), 32'(16));
        step(1'b1, 8'h60, 1'b0, 1'b1);
        check("t3_transition_ready", 32'(s_srdy), 32'(0));
        send(8'h50, 16, 4, 20, 1'b1, 4, sent);
        check("t3_discarded", 32'(sent), 32'(4));
        idle(2, 1'b1);
        check("t3_drop_count", 32'(drop_count), 32'(1));
        check("t3_never_valid", 32'(rv_cycles - t1), 32'(0));
        send(8'h90, 0, 2, 2, 1'b1, 10, sent);
        idle(5, 1'b1);
        check("t3_small_sent", 32'(sent), 32'(2));
        check("t3_small_delivered", 32'(out_beats - t0), 32'(2));

        // 4. Exact fit: 16-beat packet with the output stalled
        t0 = out_beats;
        t1 = out_lasts;
        send(8'hA0, 0, 16, 16, 1'b0, 16, sent);
        check("t4_sent", 32'(sent), 32'(16));
        idle(1, 1'b0);
        check("t4_pkt_count", 32'(s_pc), 32'(1));
        check("t4_src_ready_low", 32'(s_srdy), 32'(0));
        check("t4_drop_count", 32'(drop_count), 32'(1));
        idle(20, 1'b1);
        check("t4_delivered", 32'(out_beats - t0), 32'(16));
        check("t4_one_last", 32'(out_lasts - t1), 32'(1));

        // 5. Reset in the middle of a packet, with a committed packet pending
        send(8'hB0, 0, 2, 2, 1'b0, 4, sent);
        send(8'hC0, 0, 3, 5, 1'b0, 3, sent);
        rst = 1'b1;
        #1;
        check("t5_rst_res_TVALID", 32'(res_TVALID), 32'(0));
        check("t5_rst_src_TREADY", 32'(src_TREADY), 32'(0));
        check("t5_rst_pkt_count", 32'(pkt_count), 32'(0));
        check("t5_rst_drop_count", 32'(drop_count), 32'(0));
        src_TVALID = 1'b0;
        exp_q.delete();
        cur_q.delete();
        com_pkts = 0;
        rd_pkts = 0;
        drops_m = 0;
        out_pkt_len = 0;
        prev_rv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 1'b1);
        check("t5_ready_after", 32'(s_srdy), 32'(1));
        t0 = out_beats;
        send(8'hD0, 0, 3, 3, 1'b1, 6, sent);
        idle(5, 1'b1);
        check("t5_new_pkt", 32'(out_beats - t0), 32'(3));

        // 6. Random soak: 2000 packets of 1..16 beats
        t0 = out_beats;
        p = 0;
        b = 0;
        len = $urandom_range(1, 16);
        dd = DW'($urandom);
        cyc = 0;
        sent_beats = 0;
        while ((p < 2000 || exp_q.size() != 0) && cyc < 90000) begin
            vv = (p < 2000) && ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            step(vv, dd, b == len - 1, rr);
            if (last_in_hs) begin
                sent_beats++;
                dd = DW'($urandom);
                b++;
                if (b == len) begin
                    b = 0;
                    p++;
                    len = $urandom_range(1, 16);
                end
            end
            cyc++;
        end
        check("soak_in_budget", 32'(cyc < 90000), 32'(1));
        check("soak_beats", 32'(out_beats - t0), 32'(sent_beats));
        check("soak_drop_count", 32'(drop_count), 32'(0));
        idle(1, 1'b1);
        check("soak_pkt_count", 32'(s_pc), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
